// File: rtl/lsu_pkg.sv
// lsu_pkg: mem_op encodings, access sizes and controller states shared by the LSU files.
package lsu_pkg;
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    // Reserved funct3 codes (011/110/111) fall through to word size.
    function automatic logic [1:0] op_size(input logic [1:0] lo);
        return lo == 2'b00 ? SZ_B : lo == 2'b01 ? SZ_H : SZ_W;
    endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: req/gnt/rvalid data-memory bus between the LSU (master) and memory (slave).
interface lsu_ctrl_if #(parameter int ADDR_W = 32) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: selects the addressed lane of a read word and sign/zero-extends it.
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    output logic [31:0] res
);
    logic [31:0] sh;
    logic [1:0]  sz;
    logic        sgn;
    assign sh  = rdata >> {off, 3'b000};
    assign sz  = op_size(op[1:0]);
    assign sgn = ~op[2];
    assign res = sz == SZ_B ? {{24{sgn & sh[7]}}, sh[7:0]} :
                 sz == SZ_H ? {{16{sgn & sh[15]}}, sh[15:0]} : rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store controller; one bus transaction per instruction, stalls the pipe meanwhile.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [2:0]        mem_op_i,
    input  logic              mem_wren_i,
    input  logic              is_load_i,
    output logic              stall_o,
    output logic [31:0]       ld_data_o,
    output logic              misalign_o,
    lsu_ctrl_if.master        dmem
);
    state_e      state_q, state_d;
    logic [31:0] ld_q, fmt;
    logic [1:0]  sz, off;
    logic        access, mis, go, req;
    assign off    = addr_i[1:0];
    assign sz     = op_size(mem_op_i[1:0]);
    assign access = is_load_i | mem_wren_i;
    assign mis    = (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
    // Gating with reset drops the request the moment reset asserts, even with stale inputs.
    assign go         = reset_ni & access & ~mis;
    assign misalign_o = reset_ni & access & mis;
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall_o = 1'b0;
        unique case (state_q)
            IDLE, REQ: begin
                req     = go;
                stall_o = go;
                state_d = !go ? IDLE : dmem.gnt ? (mem_wren_i ? DONE : WAIT) : REQ;
            end
            WAIT: begin
                stall_o = 1'b1;
                state_d = dmem.rvalid ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    assign dmem.req   = req;
    assign dmem.we    = req & mem_wren_i;
    assign dmem.addr  = {addr_i[ADDR_W-1:2], 2'b00};
    assign dmem.be    = !req ? 4'b0000 : sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : 4'b1111;
    assign dmem.wdata = sz == SZ_B ? {4{st_data_i[7:0]}} : sz == SZ_H ? {2{st_data_i[15:0]}} : st_data_i;
    lsu_load_fmt u_fmt (.rdata(dmem.rdata), .off(off), .op(mem_op_i), .res(fmt));
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ld_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT && dmem.rvalid) ld_q <= fmt;
        end
    end
    assign ld_data_o = ld_q;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the MEM stage: consumes the registered MEM-stage signals (address from the ALU, rs2 store data, mem_op, write enable, is_load) and runs one data-memory transaction per instruction over a req/gnt/rvalid bus. While a transaction is in flight it freezes the pipeline through `stall_o`, which drives the pipeline-register enables. It returns sign- or zero-extended load data toward writeback and flags misaligned accesses without touching memory.

## Interface
- ADDR_W, 32, address width; data width is fixed at 32
- clk_i  in  1  clock, rising edge
- reset_ni  in  1  asynchronous, active-low reset
- addr_i  in  ADDR_W  byte address (MEM-stage ALU result)
- st_data_i  in  32  store data (MEM-stage rs2)
- mem_op_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- mem_wren_i  in  1  instruction is a store
- is_load_i  in  1  instruction is a load
- stall_o  out  1  freeze fetch..MEM pipeline registers
- ld_data_o  out  32  formatted load result, valid in DONE
- misalign_o  out  1  current access is misaligned, no memory access made
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_W  word address: {addr_i[ADDR_W-1:2], 2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid, at least 1 cycle after gnt
- dmem_rdata_i  in  32  read word

## Operation
- access = is_load_i | mem_wren_i. If both are set, the store wins.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Then misalign_o=1 combinationally, there is no request, stall_o=0, and the FSM stays in IDLE.
- Op codes 011/110/111 are treated as W.
- FSM states:
  - IDLE:
    - If access and aligned: assert dmem_req_o and stall_o=1.
    - On gnt: a store goes to DONE, a load goes to WAIT.
    - No gnt: go to REQ.
    - Otherwise: no request, stall_o=0.
  - REQ: dmem_req_o=1, stall_o=1. Same gnt transitions as IDLE.
  - WAIT: stall_o=1, no request. On rvalid, register the formatted rdata into ld_q and go to DONE.
  - DONE: stall_o=0, no request. Go to IDLE. The pipeline advances at the end of this cycle, so the same instruction is never reissued.
- Request fields are combinational from the inputs. The inputs are held stable because stall_o freezes the upstream register.
- Byte enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<addr[1:0]
  - W: 4'b1111
- Write data:
  - B: byte replicated ×4
  - H: half replicated ×2
  - W: unchanged
- Load formatting:
  - Select the lane by addr[1:0].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- ld_data_o = ld_q at all times. A store leaves ld_q unchanged.
- rvalid in IDLE, REQ or DONE is ignored.

## Timing
- Reset values:
  - state=IDLE, ld_q=0
  - ld_data_o=0, stall_o=0, dmem_req_o=0, misalign_o=0, dmem_we_o=0, dmem_be_o=0
  - dmem_addr_o and dmem_wdata_o follow the inputs.
- Zero-wait store: request cycle (stall=1), then DONE. The instruction leaves MEM after 2 cycles.
- Zero-wait load: request+gnt, then WAIT+rvalid, then DONE. 3 cycles. Each extra gnt or rvalid wait cycle adds 1.
- Back-to-back accesses: every access passes through DONE and IDLE, so no two requests are granted in adjacent cycles.
- Reset mid-operation: async return to IDLE and req drops immediately. A late rvalid after reset is ignored.
- A non-memory instruction costs 0 cycles and never asserts stall.

## Structure
- lsu_pkg holds:
  - mem_op constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU)
  - state_e enum {IDLE, REQ, WAIT, DONE}
- Sub-module lsu_load_fmt: purely combinational lane select and extension (rdata, addr[1:0], mem_op → 32-bit result). It is instantiated once and reused by the bench as a reference model.

## Test plan
- LB at addr 0x103, rdata 0x80FF_1234, gnt and rvalid immediate → stall 1,1,0 over 3 cycles; ld_data_o=0xFFFF_FF80 in DONE.
- LHU at 0x102, rdata 0x8001_0000, gnt delayed 2 cycles → req held through REQ, 5-cycle occupancy, ld_data_o=0x0000_8001.
- SB at 0x201, st_data 0x0000_00AB, immediate gnt → be=0010, wdata=0xABAB_ABAB, dmem_we_o=1, addr 0x200, 2 cycles.
- SW at 0x102 → misalign_o=1, no dmem_req_o, stall_o=0.
- Reset asserted in WAIT, then rvalid arrives → state IDLE, stall_o=0, ld_data_o=0.
- ADD followed by an LW with rvalid 3 cycles after gnt → ADD has 0 stall; LW stalls 4 cycles and is released in DONE, after which the FSM is in IDLE.
